// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and helpers for the sync and drawing stages.
package vga_pkg;

  localparam int unsigned CountW = 10;
  typedef logic [CountW-1:0] coord_t;

  localparam int unsigned ClkDivDef = 4;

  localparam int unsigned HDisplay = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned HTotal   = HDisplay + HFront + HSync + HBack;

  localparam int unsigned VDisplay = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;
  localparam int unsigned VTotal   = VDisplay + VFront + VSync + VBack;

  localparam int unsigned HSyncStart = HDisplay + HFront;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;
  localparam int unsigned VSyncStart = VDisplay + VFront;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Generic modulo-M counter: counts 0..M-1 while en is high, flags the terminal count.
module mod_m_counter #(
  parameter int unsigned M = 10,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [N-1:0] q,
  output logic         max_tick
);

  localparam logic [N-1:0] QMax = N'(M - 1);

  logic [N-1:0] q_q, q_d;

  assign max_tick = (q_q == QMax);
  assign q        = q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = max_tick ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel-rate divider, x/y scan counters and zero-skew registered syncs.
module vga_sync
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = ClkDivDef,
  parameter int unsigned H_DISPLAY = HDisplay,
  parameter int unsigned H_FRONT   = HFront,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BACK    = HBack,
  parameter int unsigned V_DISPLAY = VDisplay,
  parameter int unsigned V_FRONT   = VFront,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BACK    = VBack
) (
  input  logic              clk,
  input  logic              reset,
  output logic              p_tick,
  output logic [CountW-1:0] pix_x,
  output logic [CountW-1:0] pix_y,
  output logic              video_on,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_tick
);

  localparam int unsigned HTot = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTot = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam coord_t HDisp = CountW'(H_DISPLAY);
  localparam coord_t VDisp = CountW'(V_DISPLAY);
  localparam coord_t HsLo  = CountW'(H_DISPLAY + H_FRONT);
  localparam coord_t HsHi  = CountW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VsLo  = CountW'(V_DISPLAY + V_FRONT);
  localparam coord_t VsHi  = CountW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DivW-1:0] div_q;
  logic            unused_div_q;
  logic            div_tick, h_max, v_max, line_end;
  coord_t          x_q, y_q, x_d, y_d;
  logic            hsync_q, vsync_q;

  mod_m_counter #(
    .M(CLK_DIV),
    .N(DivW)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .en      (1'b1),
    .q       (div_q),
    .max_tick(div_tick)
  );

  assign unused_div_q = ^div_q;

  // Gated by reset so a CLK_DIV=1 build still shows p_tick low while held in reset.
  assign p_tick   = reset & div_tick;
  assign line_end = p_tick & h_max;

  mod_m_counter #(
    .M(HTot),
    .N(CountW)
  ) u_hcnt (
    .clk     (clk),
    .reset   (reset),
    .en      (p_tick),
    .q       (x_q),
    .max_tick(h_max)
  );

  mod_m_counter #(
    .M(VTot),
    .N(CountW)
  ) u_vcnt (
    .clk     (clk),
    .reset   (reset),
    .en      (line_end),
    .q       (y_q),
    .max_tick(v_max)
  );

  // Mirror of the counters' next state so the sync registers update on the same edge.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      x_d = h_max ? '0 : x_q + CountW'(1);
      if (h_max) begin
        y_d = v_max ? '0 : y_q + CountW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hsync_q <= ~in_window(x_d, HsLo, HsHi);
      vsync_q <= ~in_window(y_d, VsLo, VsHi);
    end
  end

  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = (x_q < HDisp) && (y_q < VDisp);
  assign frame_tick = line_end & v_max;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default 640x480 timing plus a tiny CLK_DIV=1 build for frame-level checks.
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_pt, a_von, a_hs, a_vs, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_von, b_hs, b_vs, b_ft;
  logic [9:0] b_x, b_y;

  vga_sync dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .p_tick    (a_pt),
    .pix_x     (a_x),
    .pix_y     (a_y),
    .video_on  (a_von),
    .hsync     (a_hs),
    .vsync     (a_vs),
    .frame_tick(a_ft)
  );

  // 14 x 10 total, visible 8 x 6, hsync x in [10,12], vsync y in [7,8]; frame = 140 clks.
  vga_sync #(
    .CLK_DIV  (1),
    .H_DISPLAY(8),
    .H_FRONT  (2),
    .H_SYNC   (3),
    .H_BACK   (1),
    .V_DISPLAY(6),
    .V_FRONT  (1),
    .V_SYNC   (2),
    .V_BACK   (1)
  ) dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .p_tick    (b_pt),
    .pix_x     (b_x),
    .pix_y     (b_y),
    .video_on  (b_von),
    .hsync     (b_hs),
    .vsync     (b_vs),
    .frame_tick(b_ft)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  typedef struct {
    int         k;
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       ft;
  } vec_t;

  function automatic vec_t mk(int k, logic pt, int x, int y, logic hs, logic vs, logic von,
                              logic ft);
    vec_t v;
    v.k = k; v.pt = pt; v.x = 10'(x); v.y = 10'(y);
    v.hs = hs; v.vs = vs; v.von = von; v.ft = ft;
    return v;
  endfunction

  function automatic logic [24:0] pack(logic pt, logic [9:0] x, logic [9:0] y, logic hs,
                                       logic vs, logic von, logic ft);
    return {pt, x, y, hs, vs, von, ft};
  endfunction

  vec_t vecs[14];

  int k;
  int hs_cnt, first_x, ft_cnt, von_cnt, ft_first, ft_second;
  int mx, my;
  logic e_hs, e_vs, e_von, e_ft;

  initial begin
    // k = rising edges since reset release; sampled 1 ns after the edge.
    vecs[0]  = mk(0,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[1]  = mk(3,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(4,    1'b0, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[3]  = mk(8,    1'b0, 2,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mk(15,   1'b1, 3,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[5]  = mk(16,   1'b0, 4,   0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[6]  = mk(2559, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[7]  = mk(2560, 1'b0, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(2623, 1'b1, 655, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(2624, 1'b0, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(3007, 1'b1, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(3008, 1'b0, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(3199, 1'b1, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(3200, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Held in reset.
    repeat (3) @(posedge clk);
    #1;
    check("a_in_reset", 64'(pack(a_pt, a_x, a_y, a_hs, a_vs, a_von, a_ft)),
          64'(pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0)));
    check("b_in_reset", 64'(pack(b_pt, b_x, b_y, b_hs, b_vs, b_von, b_ft)),
          64'(pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0)));

    // Default timing: first line against the vector table.
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      while (k < vecs[i].k) begin
        @(posedge clk);
        k++;
      end
      #1;
      check($sformatf("a_vec k=%0d", vecs[i].k),
            64'(pack(a_pt, a_x, a_y, a_hs, a_vs, a_von, a_ft)),
            64'(pack(vecs[i].pt, vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].von,
                     vecs[i].ft)));
    end

    // Second line: hsync pulse width and start position.
    hs_cnt = 0;
    first_x = -1;
    for (int i = 0; i < 3200; i++) begin
      @(posedge clk);
      #1;
      if (a_pt && !a_hs) begin
        if (hs_cnt == 0) first_x = int'(a_x);
        hs_cnt++;
      end
    end
    check("a_hsync_width", 64'(hs_cnt), 64'd96);
    check("a_hsync_start", 64'(first_x), 64'd656);
    check("a_line2_wrap", 64'({a_x, a_y}), 64'({10'd0, 10'd2}));

    // Tiny CLK_DIV=1 build: asynchronous reset mid-line, then cycle-by-cycle model.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("b_async_reset", 64'(pack(b_pt, b_x, b_y, b_hs, b_vs, b_von, b_ft)),
          64'(pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("b_ptick_after_release", 64'(b_pt), 64'd1);
    ft_cnt = 0; von_cnt = 0; ft_first = -1; ft_second = -1;
    for (int kk = 1; kk <= 389; kk++) begin
      @(posedge clk);
      #1;
      mx = kk % 14;
      my = (kk / 14) % 10;
      e_hs  = !(mx >= 10 && mx <= 12);
      e_vs  = !(my >= 7 && my <= 8);
      e_von = (mx < 8) && (my < 6);
      e_ft  = (mx == 13) && (my == 9);
      check($sformatf("b_scan k=%0d", kk), 64'(pack(b_pt, b_x, b_y, b_hs, b_vs, b_von, b_ft)),
            64'(pack(1'b1, 10'(mx), 10'(my), e_hs, e_vs, e_von, e_ft)));
      if (b_ft) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = kk;
        else if (ft_second < 0) ft_second = kk;
      end
      if (kk <= 280 && b_von) von_cnt++;
    end
    check("b_frame_ticks", 64'(ft_cnt), 64'd2);
    check("b_frame_period", 64'(ft_second - ft_first), 64'd140);
    check("b_visible_count", 64'(von_cnt), 64'd96);
    check("b_pre_reset_pos", 64'(pack(b_pt, b_x, b_y, b_hs, b_vs, b_von, b_ft)),
          64'(pack(1'b1, 10'd11, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0)));

    // Reset while both syncs are active: everything clears at once.
    #2 rst_n = 1'b0;
    #1;
    check("b_midframe_reset", 64'(pack(b_pt, b_x, b_y, b_hs, b_vs, b_von, b_ft)),
          64'(pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0)));
    check("a_midframe_reset", 64'(pack(a_pt, a_x, a_y, a_hs, a_vs, a_von, a_ft)),
          64'(pack(1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0)));
    @(negedge clk);
    rst_n = 1'b1;
    ft_cnt = 0;
    for (int kk = 1; kk <= 139; kk++) begin
      @(posedge clk);
      #1;
      if (kk == 1) check("b_restart_x", 64'({b_x, b_y}), 64'({10'd1, 10'd0}));
      if (b_ft) ft_cnt++;
    end
    check("b_no_stray_ft", 64'(ft_cnt), 64'd1);
    check("b_ft_at_frame_end", 64'(b_ft), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
